// File: rtl/survivor_mem_arbiter.sv
// -----------------------------------------------------------------------------
// survivor_mem_arbiter
//   Owns the single-port survivor-path RAM of the Viterbi decoder. The ACS
//   write stream and the traceback read engine share the port. ACS writes
//   always win. Traceback reads use request/grant with one read outstanding.
//
// Ports
//   Clock1, Reset        decoder ACS clock; asynchronous active-low reset
//   Active, Hold         decoder running; end-of-page strobe from CONTROL
//   ACSSegment, ACSPage  RAM location of the current ACS write
//   acs_wr_valid/_data   ACS survivor word and its qualifier
//   TB_EN                traceback enable; tb_rd_req is ignored while low
//   tb_rd_req/_page/_seg read request, held high until tb_rd_grant
//   tb_rd_grant          pulse: the read drives the RAM port this cycle
//   tb_rd_valid/_data    pulse when read data is captured; data held after
//   tb_ready             enough completed pages exist for traceback
//   tb_starve            sticky: a read was deferred for MAX_WAIT cycles
//   ram_cs/_we/_addr/_wdata/_rdata  RAM port (rdata one cycle after a read)
//   dbg_state_o          current read FSM state (0 idle, 1 rd, 2 wait)
//
// Handshake: tb_rd_req is a level held by traceback until tb_rd_grant pulses.
// The request is accepted (grant) only in IDLE, in a cycle with no ACS write
// and no conflict with the page under write. tb_rd_valid pulses two cycles
// after grant. No backpressure exists on the result side.
// -----------------------------------------------------------------------------
module survivor_mem_arbiter #(
  parameter int WD_FSM       = 6,
  parameter int WD_DEPTH     = 5,
  parameter int WD_DATA      = 8,
  parameter int TB_MIN_PAGES = 4,
  parameter int MAX_WAIT     = 255
) (
  input  logic                       Clock1,
  input  logic                       Reset,
  input  logic                       Active,
  input  logic                       Hold,
  input  logic [WD_FSM-1:0]          ACSSegment,
  input  logic [WD_DEPTH-1:0]        ACSPage,
  input  logic                       acs_wr_valid,
  input  logic [WD_DATA-1:0]         acs_wr_data,
  input  logic                       TB_EN,
  input  logic                       tb_rd_req,
  input  logic [WD_DEPTH-1:0]        tb_rd_page,
  input  logic [WD_FSM-1:0]          tb_rd_seg,
  output logic                       tb_rd_grant,
  output logic                       tb_rd_valid,
  output logic [WD_DATA-1:0]         tb_rd_data,
  output logic                       tb_ready,
  output logic                       tb_starve,
  output logic                       ram_cs,
  output logic                       ram_we,
  output logic [WD_DEPTH+WD_FSM-1:0] ram_addr,
  output logic [WD_DATA-1:0]         ram_wdata,
  input  logic [WD_DATA-1:0]         ram_rdata,
  output logic [1:0]                 dbg_state_o
);

  localparam int WD_ADDR = WD_DEPTH + WD_FSM;
  localparam logic [7:0]          WAIT_MAX_C  = 8'(MAX_WAIT);
  localparam logic [WD_DEPTH-1:0] PAGES_MAX_C = '1;
  localparam logic [WD_DEPTH-1:0] MIN_PAGES_C = WD_DEPTH'(TB_MIN_PAGES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,  // read address is on the RAM port
    S_WAIT = 2'd2   // RAM returns data; captured at the end of this cycle
  } state_t;

  state_t state_q, state_d;

  logic                wr_now;
  logic                conflict;
  logic                rd_go;
  logic                deferred;

  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [WD_ADDR-1:0]  addr_q, addr_d;
  logic [WD_DATA-1:0]  wdata_q, wdata_d;
  logic                grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [WD_DATA-1:0]  rdata_q, rdata_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                starve_q, starve_d;
  logic [WD_DEPTH-1:0] pages_q, pages_d;
  logic                ready_q, ready_d;

  // Arbitration decision for this cycle; takes effect on the port next cycle.
  assign wr_now   = Active & acs_wr_valid;
  assign conflict = Active & (tb_rd_page == ACSPage);
  assign rd_go    = (state_q == S_IDLE) & TB_EN & tb_rd_req & ~wr_now & ~conflict;
  assign deferred = (state_q == S_IDLE) & TB_EN & tb_rd_req & ~rd_go;

  // State register
  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rd_go) state_d = S_RD;
      S_RD:    state_d = S_WAIT;
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cs_d       = wr_now | rd_go;
    we_d       = wr_now;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_d    = rd_go;
    valid_d    = (state_q == S_WAIT);
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q | (wait_cnt_q == WAIT_MAX_C);
    pages_d    = pages_q;
    ready_d    = (pages_q >= MIN_PAGES_C);

    if (wr_now) begin
      addr_d  = {ACSPage, ACSSegment};
      wdata_d = acs_wr_data;
    end else if (rd_go) begin
      addr_d  = {tb_rd_page, tb_rd_seg};
    end

    if (state_q == S_WAIT) rdata_d = ram_rdata;

    // Counter clears on grant or withdrawn request and saturates otherwise.
    if (!tb_rd_req || rd_go)                    wait_cnt_d = '0;
    else if (deferred && wait_cnt_q != WAIT_MAX_C) wait_cnt_d = wait_cnt_q + 8'd1;

    if (Active && Hold && pages_q != PAGES_MAX_C) pages_d = pages_q + WD_DEPTH'(1);
  end

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      grant_q    <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
      pages_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
      pages_q    <= pages_d;
      ready_q    <= ready_d;
    end
  end

  assign ram_cs      = cs_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign tb_rd_grant = grant_q;
  assign tb_rd_valid = valid_q;
  assign tb_rd_data  = rdata_q;
  assign tb_starve   = starve_q;
  assign tb_ready    = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_survivor_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_survivor_mem_arbiter
//   Drives ACS writes, traceback reads, Hold pulses and resets into
//   survivor_mem_arbiter. A small RAM model answers the RAM port. Expected
//   writes and read data are queued when driven and compared when the DUT
//   produces them.
// -----------------------------------------------------------------------------
module tb_survivor_mem_arbiter;

  localparam int WD_FSM   = 6;
  localparam int WD_DEPTH = 5;
  localparam int WD_DATA  = 8;
  localparam int WD_ADDR  = WD_FSM + WD_DEPTH;

  logic                Clock1;
  logic                Reset;
  logic                Active;
  logic                Hold;
  logic [WD_FSM-1:0]   ACSSegment;
  logic [WD_DEPTH-1:0] ACSPage;
  logic                acs_wr_valid;
  logic [WD_DATA-1:0]  acs_wr_data;
  logic                TB_EN;
  logic                tb_rd_req;
  logic [WD_DEPTH-1:0] tb_rd_page;
  logic [WD_FSM-1:0]   tb_rd_seg;
  logic                tb_rd_grant;
  logic                tb_rd_valid;
  logic [WD_DATA-1:0]  tb_rd_data;
  logic                tb_ready;
  logic                tb_starve;
  logic                ram_cs;
  logic                ram_we;
  logic [WD_ADDR-1:0]  ram_addr;
  logic [WD_DATA-1:0]  ram_wdata;
  logic [WD_DATA-1:0]  ram_rdata;
  logic [1:0]          dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [WD_DATA-1:0]         rd_exp_q[$];
  logic [WD_ADDR+WD_DATA-1:0] wr_exp_q[$];

  // RAM model: random initial image plus whatever the DUT writes.
  logic [WD_DATA-1:0] init_mem [0:(1<<WD_ADDR)-1];
  logic [WD_DATA-1:0] wr_mem   [0:(1<<WD_ADDR)-1];
  logic               written  [0:(1<<WD_ADDR)-1];

  survivor_mem_arbiter dut (
    .Clock1       (Clock1),
    .Reset        (Reset),
    .Active       (Active),
    .Hold         (Hold),
    .ACSSegment   (ACSSegment),
    .ACSPage      (ACSPage),
    .acs_wr_valid (acs_wr_valid),
    .acs_wr_data  (acs_wr_data),
    .TB_EN        (TB_EN),
    .tb_rd_req    (tb_rd_req),
    .tb_rd_page   (tb_rd_page),
    .tb_rd_seg    (tb_rd_seg),
    .tb_rd_grant  (tb_rd_grant),
    .tb_rd_valid  (tb_rd_valid),
    .tb_rd_data   (tb_rd_data),
    .tb_ready     (tb_ready),
    .tb_starve    (tb_starve),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clock1 = 1'b1;
    forever #5 Clock1 = ~Clock1;  // posedges at 10, 20, ...; negedges at 5, 15, ...
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  initial begin
    for (int a = 0; a < (1 << WD_ADDR); a++) init_mem[a] = WD_DATA'($urandom_range(0, 255));
  end

  function automatic logic [WD_DATA-1:0] ram_peek(input logic [WD_ADDR-1:0] a);
    return (written[a] === 1'b1) ? wr_mem[a] : init_mem[a];
  endfunction

  always @(posedge Clock1) begin
    if (ram_cs && !ram_we) ram_rdata <= ram_peek(ram_addr);
    if (ram_cs && ram_we) begin
      wr_mem[ram_addr]  <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every RAM write and every tb_rd_valid pops one expectation.
  always @(negedge Clock1) begin
    logic [WD_ADDR+WD_DATA-1:0] we;
    logic [WD_DATA-1:0]         re;
    if (Reset === 1'b1) begin
      if (ram_cs && ram_we) begin
        if (wr_exp_q.size() != 0) we = wr_exp_q.pop_front();
        else                      we = ~{ram_addr, ram_wdata};
        check_eq("ram_write", {ram_addr, ram_wdata}, we);
      end
      if (tb_rd_valid) begin
        if (rd_exp_q.size() != 0) re = rd_exp_q.pop_front();
        else                      re = ~tb_rd_data;
        check_eq("rd_data", tb_rd_data, re);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic acs_write(input logic [WD_DEPTH-1:0] page, input logic [WD_FSM-1:0] seg,
                           input logic [WD_DATA-1:0] data);
    Active       = 1'b1;
    acs_wr_valid = 1'b1;
    ACSPage      = page;
    ACSSegment   = seg;
    acs_wr_data  = data;
    wr_exp_q.push_back({page, seg, data});
    @(negedge Clock1);
    acs_wr_valid = 1'b0;
  endtask

  task automatic hold_pulse();
    Active = 1'b1;
    Hold   = 1'b1;
    @(negedge Clock1);
    Hold   = 1'b0;
    @(negedge Clock1);
  endtask

  // Issues a read and checks grant address and valid latency. waited reports
  // the number of cycles from driving the request to seeing the grant.
  task automatic tb_read(input logic [WD_DEPTH-1:0] page, input logic [WD_FSM-1:0] seg,
                         input logic [WD_DATA-1:0] exp, input bit drop_en, output int waited);
    bit granted;
    granted    = 1'b0;
    waited     = 0;
    tb_rd_page = page;
    tb_rd_seg  = seg;
    tb_rd_req  = 1'b1;
    rd_exp_q.push_back(exp);
    for (int i = 0; i < 600 && !granted; i++) begin
      @(negedge Clock1);
      waited++;
      if (tb_rd_grant) granted = 1'b1;
    end
    tb_rd_req = 1'b0;
    check_eq("rd_granted", granted, 1);
    if (granted) begin
      check_eq("rd_addr", ram_addr, {page, seg});
      check_eq("rd_cs_we", {ram_cs, ram_we}, 2'b10);
      if (drop_en) TB_EN = 1'b0;
      @(negedge Clock1);
      check_eq("rd_valid_early", tb_rd_valid, 0);
      @(negedge Clock1);
      check_eq("rd_valid_n3", tb_rd_valid, 1);
      TB_EN = 1'b1;
    end else begin
      void'(rd_exp_q.pop_back());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bit g;
    Reset = 1'b0; Active = 1'b0; Hold = 1'b0; ACSSegment = '0; ACSPage = '0;
    acs_wr_valid = 1'b0; acs_wr_data = '0; TB_EN = 1'b1; tb_rd_req = 1'b0;
    tb_rd_page = '0; tb_rd_seg = '0;
    for (int a = 0; a < (1 << WD_ADDR); a++) written[a] = 1'b0;

    // 1. reset state and idle port
    #20;
    check_eq("reset_ctl", {tb_rd_grant, tb_rd_valid, tb_ready, tb_starve, ram_cs, ram_we, dbg_state_o}, 0);
    check_eq("reset_data", {tb_rd_data, ram_addr, ram_wdata}, 0);
    #35;  // Reset released at 55 ns, on a negedge
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock1);
      check_eq("idle_cs", {ram_cs, tb_rd_grant, tb_rd_valid}, 0);
    end

    // 2. single write
    acs_write(5'd2, 6'd5, 8'hA5);
    check_eq("wr_port", {ram_cs, ram_we, ram_addr, ram_wdata}, {2'b11, 11'h085, 8'hA5});
    Active = 1'b0;
    @(negedge Clock1);
    check_eq("wr_idle", {ram_cs, ram_we, ram_addr, ram_wdata}, {2'b00, 11'h085, 8'hA5});

    // 3. plain read, readback of the write, back-to-back reads, TB_EN drop
    tb_read(5'd1, 6'd3, init_mem[11'h043], 1'b0, w);
    check_eq("rd_latency", w, 1);
    tb_read(5'd2, 6'd5, 8'hA5, 1'b0, w);
    check_eq("rd_back_to_back", w, 1);
    tb_read(5'd4, 6'd9, init_mem[{5'd4, 6'd9}], 1'b1, w);
    check_eq("rd_tben_drop_latency", w, 1);

    // 4. read starved by continuous writes
    tb_rd_page = 5'd10;
    tb_rd_seg  = 6'd1;
    tb_rd_req  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      acs_write(5'd3, 6'(i % 64), WD_DATA'($urandom_range(0, 255)));
      acs_wr_valid = 1'b1;  // keep writes back-to-back
      check_eq("no_grant_under_wr", tb_rd_grant, 0);
      if (i == 199) check_eq("starve_not_yet", tb_starve, 0);
    end
    acs_wr_valid = 1'b0;
    check_eq("starve_set", tb_starve, 1);
    tb_read(5'd10, 6'd1, init_mem[{5'd10, 6'd1}], 1'b0, w);
    check_eq("grant_first_free", w, 1);
    check_eq("starve_sticky", tb_starve, 1);

    // 5. page conflict
    Active  = 1'b1;
    ACSPage = 5'd7;
    tb_rd_page = 5'd7;
    tb_rd_seg  = 6'd2;
    tb_rd_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock1);
      check_eq("conflict_defer", tb_rd_grant, 0);
    end
    ACSPage = 5'd8;
    tb_read(5'd7, 6'd2, init_mem[{5'd7, 6'd2}], 1'b0, w);
    check_eq("conflict_release", w, 1);

    // 6. page count, then reset during WAIT
    for (int i = 0; i < 3; i++) hold_pulse();
    @(negedge Clock1);
    check_eq("ready_after3", tb_ready, 0);
    hold_pulse();
    @(negedge Clock1);
    check_eq("ready_after4", tb_ready, 1);

    Active     = 1'b0;
    tb_rd_page = 5'd2;
    tb_rd_seg  = 6'd9;
    tb_rd_req  = 1'b1;
    g = 1'b0;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge Clock1);
      if (tb_rd_grant) g = 1'b1;
    end
    check_eq("abort_granted", g, 1);
    tb_rd_req = 1'b0;
    @(negedge Clock1);
    check_eq("abort_in_wait", dbg_state_o, 2);
    #1 Reset = 1'b0;
    #2;
    check_eq("abort_reset_ctl", {tb_rd_valid, tb_ready, tb_starve, ram_cs, dbg_state_o}, 0);
    @(negedge Clock1);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock1);
      check_eq("abort_no_valid", tb_rd_valid, 0);
    end
    for (int i = 0; i < 3; i++) hold_pulse();
    @(negedge Clock1);
    check_eq("pages_cleared", tb_ready, 0);
    Active = 1'b0;

    // random reads with no writer
    for (int i = 0; i < 8; i++) begin
      logic [WD_DEPTH-1:0] p;
      logic [WD_FSM-1:0]   s;
      p = WD_DEPTH'($urandom_range(0, 31));
      s = WD_FSM'($urandom_range(0, 63));
      tb_read(p, s, ram_peek({p, s}), 1'(i % 3 == 0), w);
      check_eq("rand_rd_latency", w, 1);
    end

    repeat (3) @(negedge Clock1);
    check_eq("rd_q_drained", rd_exp_q.size(), 0);
    check_eq("wr_q_drained", wr_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
